// File: rtl/spi_rom_read_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_rom_read_ctrl_if
// Bundles the request/response handshake seen by the fetch logic together with
// the byte-level link to the SPI ROM engine and its chip select.
//   slave  : view taken by spi_rom_read_ctrl
//   master : view taken by the requester / engine side (testbench)
// Signals:
//   req_valid/req_ready/req_addr[23:0]/req_len[7:0] : read request
//   rd_valid/rd_data[7:0]/rd_last                   : returned ROM bytes
//   busy                                            : transaction in progress
//   cs_n                                            : ROM chip select, active-low
//   spi_tx_data[7:0]/spi_tx_valid/spi_tx_ready      : byte offered to engine
//   spi_rx_valid/spi_rx_data[7:0]                   : byte completed by engine
// -----------------------------------------------------------------------------
interface spi_rom_read_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic        busy;
  logic        cs_n;
  logic [7:0]  spi_tx_data;
  logic        spi_tx_valid;
  logic        spi_tx_ready;
  logic        spi_rx_valid;
  logic [7:0]  spi_rx_data;

  modport slave (
    input  req_valid, req_addr, req_len, spi_tx_ready, spi_rx_valid, spi_rx_data,
    output req_ready, rd_valid, rd_data, rd_last, busy, cs_n, spi_tx_data, spi_tx_valid
  );

  modport master (
    output req_valid, req_addr, req_len, spi_tx_ready, spi_rx_valid, spi_rx_data,
    input  req_ready, rd_valid, rd_data, rd_last, busy, cs_n, spi_tx_data, spi_tx_valid
  );
endinterface

// File: rtl/spi_rom_read_ctrl.sv
// -----------------------------------------------------------------------------
// spi_rom_read_ctrl
// Turns (address, length) read requests into complete dual-output SPI flash
// reads on top of a byte engine: CS low, opcode, 24-bit address, dummy bytes,
// then len+1 data bytes streamed back to the requester, then CS high again.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : spi_rom_read_ctrl_if.slave (request, read data, busy, cs_n, engine link)
// Parameters:
//   CMD_READ    : read opcode (default 8'h3B)
//   DUMMY_BYTES : 0..3 dummy 8'h00 bytes between address and data
//   CS_IDLE_CYC : minimum cycles cs_n stays high between transactions (>=1)
// Optional feature macro: SPI_ROM_CONT_READ_EN
//   When defined, CS is left asserted after a read (OPEN state); a following
//   request that continues at the next sequential address skips straight to
//   the data phase.
// -----------------------------------------------------------------------------
module spi_rom_read_ctrl #(
  parameter logic [7:0] CMD_READ    = 8'h3B,
  parameter int         DUMMY_BYTES = 1,
  parameter int         CS_IDLE_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_rom_read_ctrl_if.slave  bus
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] CS_SETUP = 4'd1;
  localparam logic [3:0] CMD      = 4'd2;
  localparam logic [3:0] ADDR2    = 4'd3;
  localparam logic [3:0] ADDR1    = 4'd4;
  localparam logic [3:0] ADDR0    = 4'd5;
  localparam logic [3:0] DUMMY    = 4'd6;
  localparam logic [3:0] DATA     = 4'd7;
  localparam logic [3:0] CS_HOLD  = 4'd8;
`ifdef SPI_ROM_CONT_READ_EN
  localparam logic [3:0] OPEN     = 4'd9;
`endif

  localparam logic [1:0] DUMMY_INIT = 2'(DUMMY_BYTES - 1);
  localparam logic [7:0] HOLD_INIT  = 8'(CS_IDLE_CYC - 1);

  logic [3:0]  state_q, state_d;
  logic        cs_n_q, cs_n_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        inflight_q, inflight_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_last_q, rd_last_d;
  logic        busy_q, busy_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  dummy_q, dummy_d;
  logic [7:0]  hold_q, hold_d;
  logic [23:0] addr_q;
`ifdef SPI_ROM_CONT_READ_EN
  logic [7:0]  len_q;
  logic        pend_q, pend_d;
  logic [23:0] nxt_q, nxt_d;
`endif

  logic req_ready_w, accept, tx_fire, rx_ok;

`ifdef SPI_ROM_CONT_READ_EN
  assign req_ready_w = (state_q == IDLE) || (state_q == OPEN);
`else
  assign req_ready_w = (state_q == IDLE);
`endif
  assign accept  = bus.req_valid & req_ready_w;
  assign tx_fire = tx_valid_q & bus.spi_tx_ready;
  // Only a byte that has been handed to the engine can complete; anything else
  // on spi_rx_valid is noise and dropped.
  assign rx_ok   = inflight_q & bus.spi_rx_valid;

  always_comb begin
    state_d    = state_q;
    cs_n_d     = cs_n_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    inflight_d = inflight_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_last_d  = 1'b0;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    dummy_d    = dummy_q;
    hold_d     = hold_q;
`ifdef SPI_ROM_CONT_READ_EN
    pend_d     = pend_q;
    nxt_d      = nxt_q;
`endif

    if (tx_fire) begin
      tx_valid_d = 1'b0;
      inflight_d = 1'b1;
    end
    if (rx_ok) inflight_d = 1'b0;

    case (state_q)
      IDLE: if (accept) begin
        state_d = CS_SETUP;
        cs_n_d  = 1'b0;
        busy_d  = 1'b1;
        cnt_d   = bus.req_len;
        dummy_d = DUMMY_INIT;
      end
      CS_SETUP: begin
        state_d    = CMD;
        tx_valid_d = 1'b1;
        tx_data_d  = CMD_READ;
      end
      CMD: if (rx_ok) begin
        state_d    = ADDR2;
        tx_valid_d = 1'b1;
        tx_data_d  = addr_q[23:16];
      end
      ADDR2: if (rx_ok) begin
        state_d    = ADDR1;
        tx_valid_d = 1'b1;
        tx_data_d  = addr_q[15:8];
      end
      ADDR1: if (rx_ok) begin
        state_d    = ADDR0;
        tx_valid_d = 1'b1;
        tx_data_d  = addr_q[7:0];
      end
      ADDR0: if (rx_ok) begin
        state_d    = (DUMMY_BYTES == 0) ? DATA : DUMMY;
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h00;
      end
      DUMMY: if (rx_ok) begin
        if (dummy_q == 2'd0) state_d = DATA;
        else                 dummy_d = dummy_q - 2'd1;
        tx_valid_d = 1'b1;
        tx_data_d  = 8'h00;
      end
      DATA: if (rx_ok) begin
        rd_valid_d = 1'b1;
        rd_data_d  = bus.spi_rx_data;
        if (cnt_q == 8'd0) begin
          rd_last_d = 1'b1;
`ifdef SPI_ROM_CONT_READ_EN
          // Keep the device selected so a sequential follow-up can resume.
          state_d = OPEN;
          busy_d  = 1'b0;
          nxt_d   = addr_q + {16'h0000, len_q} + 24'd1;
`else
          state_d = CS_HOLD;
          cs_n_d  = 1'b1;
          hold_d  = HOLD_INIT;
`endif
        end else begin
          cnt_d      = cnt_q - 8'd1;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h00;
        end
      end
      CS_HOLD: begin
        if (hold_q == 8'd0) begin
`ifdef SPI_ROM_CONT_READ_EN
          if (pend_q) begin
            // A non-sequential request was latched in OPEN; replay it in full.
            state_d = CS_SETUP;
            cs_n_d  = 1'b0;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
`ifdef SPI_ROM_CONT_READ_EN
      OPEN: if (accept) begin
        busy_d  = 1'b1;
        cnt_d   = bus.req_len;
        dummy_d = DUMMY_INIT;
        if (bus.req_addr == nxt_q) begin
          state_d    = DATA;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h00;
        end else begin
          state_d = CS_HOLD;
          cs_n_d  = 1'b1;
          hold_d  = HOLD_INIT;
          pend_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cs_n_q     <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      inflight_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= 8'h00;
      dummy_q    <= 2'd0;
      hold_q     <= 8'h00;
`ifdef SPI_ROM_CONT_READ_EN
      pend_q     <= 1'b0;
      nxt_q      <= 24'h000000;
`endif
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      inflight_q <= inflight_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      dummy_q    <= dummy_d;
      hold_q     <= hold_d;
`ifdef SPI_ROM_CONT_READ_EN
      pend_q     <= pend_d;
      nxt_q      <= nxt_d;
`endif
    end
  end

  // Request fields are plain data: captured on acceptance, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= bus.req_addr;
`ifdef SPI_ROM_CONT_READ_EN
      len_q  <= bus.req_len;
`endif
    end
  end

  assign bus.req_ready    = req_ready_w;
  assign bus.busy         = busy_q;
  assign bus.cs_n         = cs_n_q;
  assign bus.spi_tx_valid = tx_valid_q;
  assign bus.spi_tx_data  = tx_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_last      = rd_last_q;

endmodule

// File: tb/tb_spi_rom_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_rom_read_ctrl
// Randomized scoreboard bench. A behavioural flash model stands in for the
// byte engine + ROM: it counts bytes since CS fell, takes the address from
// bytes 1..3 and returns rom(addr++) once the header and dummies are past.
// Requests push the expected engine byte stream and the expected read bytes;
// the engine model and a read monitor pop and compare.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_rom_read_ctrl;
  localparam int DUMMY_BYTES = 1;
  localparam int CS_IDLE_CYC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_rom_read_ctrl_if bus ();

  spi_rom_read_ctrl #(
    .CMD_READ    (8'h3B),
    .DUMMY_BYTES (DUMMY_BYTES),
    .CS_IDLE_CYC (CS_IDLE_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_tx[$];
  logic [8:0]  exp_rd[$];   // {last, data}

  int rd_seen = 0;
  int cs_rises = 0;
  int cs_high_run = 0;
  logic cs_prev = 1'b1;

  int stray_req = 0, stray_taken = 0;
  int stall_req = 0, stall_taken = 0;
  int stall_left = 0;

  int          fbyte = 0;
  logic [23:0] fa = '0;
  bit          pend = 1'b0;
  int          lat = 0;
  logic [7:0]  resp = '0;

  bit          m_open = 1'b0;
  logic [23:0] m_next = '0;

  function automatic logic [7:0] rom(input logic [23:0] a);
    return a[7:0] + a[15:8] * 8'd3 + a[23:16] * 8'd7 + 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural flash + byte engine, driven on the falling edge.
  always @(negedge clk) begin
    logic [7:0] expv;
    bus.spi_tx_ready = 1'b0;
    bus.spi_rx_valid = 1'b0;
    if (stray_taken != stray_req) begin
      stray_taken++;
      bus.spi_rx_valid = 1'b1;
      bus.spi_rx_data  = 8'($urandom);
    end else if (bus.cs_n) begin
      fbyte = 0;
      pend  = 1'b0;
    end else if (pend) begin
      if (lat == 0) begin
        bus.spi_rx_valid = 1'b1;
        bus.spi_rx_data  = resp;
        pend = 1'b0;
      end else begin
        lat--;
      end
    end else if (stall_left > 0) begin
      stall_left--;
      expv = (exp_tx.size() > 0) ? exp_tx[0] : 8'h00;
      check("tx_stall_hold", 32'({bus.spi_tx_valid, bus.spi_tx_data}), 32'({1'b1, expv}));
    end else if (bus.spi_tx_valid) begin
      if (stall_taken != stall_req && fbyte == 2) begin
        stall_taken++;
        stall_left = 9;
        expv = (exp_tx.size() > 0) ? exp_tx[0] : 8'h00;
        check("tx_stall_hold", 32'({bus.spi_tx_valid, bus.spi_tx_data}), 32'({1'b1, expv}));
      end else if ($urandom_range(0, 3) != 0) begin
        bus.spi_tx_ready = 1'b1;
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected actual=%0h required=none", bus.spi_tx_data);
        end else begin
          check("tx_byte", 32'(bus.spi_tx_data), 32'(exp_tx.pop_front()));
        end
        if (fbyte >= 1 && fbyte <= 3) fa = {fa[15:0], bus.spi_tx_data};
        if (fbyte >= 4 + DUMMY_BYTES) begin
          resp = rom(fa);
          fa   = fa + 24'd1;
        end else begin
          resp = 8'($urandom);
        end
        fbyte++;
        pend = 1'b1;
        lat  = $urandom_range(0, 3);
      end
    end
  end

  // Read-data monitor and chip-select gap monitor.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.rd_valid === 1'b1) begin
      rd_seen++;
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%0h required=none", bus.rd_data);
      end else begin
        check("rd_byte", 32'({bus.rd_last, bus.rd_data}), 32'(exp_rd.pop_front()));
      end
    end
    if (bus.cs_n === 1'b1) begin
      cs_high_run++;
      if (!cs_prev) cs_rises++;
    end else if (bus.cs_n === 1'b0) begin
      if (cs_high_run > 0)
        check("cs_idle_gap", 32'(cs_high_run >= CS_IDLE_CYC), 32'd1);
      cs_high_run = 0;
    end
    cs_prev = (bus.cs_n !== 1'b0);
  end

  task automatic do_read(input logic [23:0] a, input logic [7:0] l);
    int g = 0;
    bit full = 1'b1;
    logic [23:0] t;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
`ifdef SPI_ROM_CONT_READ_EN
    if (m_open && a == m_next) full = 1'b0;
    m_open = 1'b1;
    m_next = a + {16'h0000, l} + 24'd1;
`endif
    if (full) begin
      exp_tx.push_back(8'h3B);
      exp_tx.push_back(a[23:16]);
      exp_tx.push_back(a[15:8]);
      exp_tx.push_back(a[7:0]);
      for (int i = 0; i < DUMMY_BYTES; i++) exp_tx.push_back(8'h00);
    end
    for (int i = 0; i <= int'(l); i++) begin
      t = a + 24'(i);
      exp_tx.push_back(8'h00);
      exp_rd.push_back({(i == int'(l)), rom(t)});
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while ((exp_rd.size() != 0 || bus.busy !== 1'b0) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20000) $display("FAIL %s_timeout actual=%0d required=0 pending", name, exp_rd.size());
    check({name, "_rd_drained"}, 32'(exp_rd.size()), 32'd0);
    check({name, "_tx_drained"}, 32'(exp_tx.size()), 32'd0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int seen0;
    int g;
    int cr;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cs_n",      32'(bus.cs_n),         32'd1);
    check("rst_tx_valid",  32'(bus.spi_tx_valid), 32'd0);
    check("rst_tx_data",   32'(bus.spi_tx_data),  32'd0);
    check("rst_rd_valid",  32'(bus.rd_valid),     32'd0);
    check("rst_rd_data",   32'(bus.rd_data),      32'd0);
    check("rst_rd_last",   32'(bus.rd_last),      32'd0);
    check("rst_busy",      32'(bus.busy),         32'd0);
    check("rst_req_ready", 32'(bus.req_ready),    32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Stray engine pulse while idle.
    seen0 = rd_seen;
    stray_req++;
    repeat (4) @(negedge clk);
    check("stray_idle_rd", 32'(rd_seen), 32'(seen0));
    check("idle_ready",    32'(bus.req_ready), 32'd1);

    // Basic read.
    do_read(24'h012345, 8'd3);
    wait_done("basic");

    // Engine back-pressure on the ADDR1 byte.
    stall_req++;
    do_read(24'h012345, 8'd1);
    wait_done("stall");
    check("stall_applied", 32'(stall_taken), 32'(stall_req));

    // Requests while busy are dropped.
    do_read(24'hABCDEF, 8'd5);
    for (int i = 0; i < 6; i++) begin
      check("busy_req_ready", 32'(bus.req_ready), 32'd0);
      bus.req_valid = 1'b1;
      bus.req_addr  = 24'($urandom);
      bus.req_len   = 8'($urandom);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    wait_done("busy_drop");

    // Address wrap at the top of the 24-bit space.
    do_read(24'hFFFFFE, 8'd3);
    wait_done("wrap");

    // Randomized requests.
    for (int i = 0; i < 8; i++) begin
      do_read(24'($urandom), 8'($urandom_range(0, 20)));
      wait_done("random");
    end

    // Maximum length.
    do_read(24'($urandom), 8'd255);
    wait_done("len256");

    // Reset in the middle of the data phase.
    do_read(24'h3FFFF0, 8'd39);
    g = 0;
    while (exp_rd.size() > 35 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("reset_in_data", 32'(exp_rd.size() <= 35), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_cs_n",     32'(bus.cs_n),     32'd1);
    check("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("midrst_busy",     32'(bus.busy),     32'd0);
    exp_rd.delete();
    exp_tx.delete();
    m_open = 1'b0;
    seen0 = rd_seen;
    stray_req++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    stray_req++;
    repeat (4) @(negedge clk);
    check("midrst_no_rd",    32'(rd_seen),       32'(seen0));
    check("midrst_ready",    32'(bus.req_ready), 32'd1);
    check("midrst_cs_high",  32'(bus.cs_n),      32'd1);

`ifdef SPI_ROM_CONT_READ_EN
    // Sequential continuation keeps CS low; a jump closes and restarts.
    do_read(24'h000100, 8'd15);
    wait_done("cont_first");
    cr = cs_rises;
    do_read(24'h000110, 8'd0);
    wait_done("cont_seq");
    check("cont_cs_stays_low", 32'(cs_rises), 32'(cr));
    check("cont_cs_n",         32'(bus.cs_n), 32'd0);
    do_read(24'h000000, 8'd2);
    wait_done("cont_jump");
    check("cont_jump_cs_rise", 32'(cs_rises > cr), 32'd1);
`else
    cr = cs_rises;
    do_read(24'h000100, 8'd0);
    wait_done("closed");
    check("closed_cs_rise", 32'(cs_rises), 32'(cr + 1));
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
